// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto a single RAM port with completion timeout.
// Optional `MEM_ARB_RR_EN: round-robin on contention instead of fixed dcache priority.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [31:0] BAD     = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  ramstate_t   rs;
  logic        i_req, d_req, d_wins, granted, done, abort, finish;

  assign rs      = ramstate_t'(ramstate);
  assign i_req   = iREN;
  assign d_req   = dREN | dWEN;
  assign granted = (state_q != IDLE);
  assign done    = granted && (rs == ACCESS);
  assign abort   = granted && !done && (cnt_q == 4'(TIMEOUT));
  assign finish  = done | abort;

`ifdef MEM_ARB_RR_EN
  // last_d_q = 1 when the dcache was the most recently served requester
  logic last_d_q, last_d_d;
  assign d_wins = d_req && (!i_req || !last_d_q);
`else
  assign d_wins = d_req;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`ifdef MEM_ARB_RR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_wins)     state_d = DGNT;
        else if (i_req) state_d = IGNT;
      end
      IGNT, DGNT: if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched transaction context; requester inputs are ignored once granted
  always_comb begin
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    err_d   = err_q | abort;
`ifdef MEM_ARB_RR_EN
    last_d_d = last_d_q;
    if (finish) last_d_d = (state_q == DGNT);
`endif
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (d_wins) begin
        addr_d  = daddr;
        store_d = dstore;
        wr_d    = dWEN;
      end else if (i_req) begin
        addr_d = iaddr;
        wr_d   = 1'b0;
      end
    end else if (!finish) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    ramREN   = granted && !wr_q;
    ramWEN   = granted && wr_q;
    ramstore = store_q;
    ramaddr  = addr_q;
    // Address lookahead in IDLE so the RAM sees it on the first grant cycle
    if (state_q == IDLE && !RST) begin
      if (d_wins)     ramaddr = daddr;
      else if (i_req) ramaddr = iaddr;
    end
    iwait = !((state_q == IGNT) && finish);
    dwait = !((state_q == DGNT) && finish);
    iload = '0;
    dload = '0;
    if (state_q == IGNT) iload = done ? ramload : (abort ? BAD : 32'h0);
    if (state_q == DGNT) dload = done ? ramload : (abort ? BAD : 32'h0);
    err = err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: latency-programmable RAM model, vector table of single
// transactions, scoreboard of expected wait pulses, and multi-cycle corner sequences.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM model: ACCESS after ram_lat enabled cycles, or BUSY forever when stuck
  int          ram_lat = 0;
  bit          ram_stuck = 1'b0;
  int          ram_cnt = 0;
  logic [31:0] mem [0:255];
  bit          mem_valid [0:255];

  function automatic logic [31:0] mem_default(input logic [7:0] a);
    return (a == 8'h40) ? 32'h12345678 : (32'h10000000 | {24'h0, a});
  endfunction

  always @(posedge CLK) begin
    if (ramREN || ramWEN) ram_cnt <= ram_cnt + 1;
    else                  ram_cnt <= 0;
    if (ramWEN && ramstate == RS_ACCESS) begin
      mem[ramaddr[7:0]]       <= ramstore;
      mem_valid[ramaddr[7:0]] <= 1'b1;
    end
  end

  always_comb begin
    ramstate = RS_FREE;
    if (ramREN || ramWEN) ramstate = (!ram_stuck && ram_cnt >= ram_lat) ? RS_ACCESS : RS_BUSY;
  end

  assign ramload = mem_valid[ramaddr[7:0]] ? mem[ramaddr[7:0]] : mem_default(ramaddr[7:0]);

  // Scoreboard of expected wait pulses
  typedef struct {
    bit          is_d;
    logic [31:0] load;
    bit          chk_load;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic sb_push(input bit is_d, input logic [31:0] load, input bit chk_load);
    exp_t e;
    e.is_d = is_d; e.load = load; e.chk_load = chk_load;
    sb_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      chk("ram_en_exclusive", {31'b0, ramREN & ramWEN}, 32'h0);
      chk("wait_exclusive", {31'b0, !iwait & !dwait}, 32'h0);
      if (iwait) chk("iload_outside", iload, 32'h0);
      if (dwait) chk("dload_outside", dload, 32'h0);
      if (!iwait || !dwait) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got iwait=%b dwait=%b expected no pulse", iwait, dwait);
        end else begin
          mon_e = sb_q.pop_front();
          chk("owner", {31'b0, !dwait}, {31'b0, mon_e.is_d});
          if (mon_e.chk_load) chk("load", !dwait ? dload : iload, mon_e.load);
          $display("txn t=%0t owner=%s load=%h", $time, !dwait ? "d" : "i", !dwait ? dload : iload);
        end
      end
    end
  end

  typedef struct {
    int          lat;
    bit          stuck;
    bit          iren;
    logic [31:0] iaddr;
    bit          dren;
    bit          dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    bit          exp_d;
    logic [31:0] exp_load;
    bit          chk_load;
    bit          exp_wr;
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_addr;
  } vec_t;

  function automatic vec_t mk(input int lat, input bit stuck, input bit ir, input logic [31:0] ia,
                              input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] ds,
                              input bit ed, input logic [31:0] el, input bit cl, input bit ew,
                              input int ec, input bit ee);
    vec_t v;
    v.lat = lat; v.stuck = stuck; v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
    v.daddr = da; v.dstore = ds; v.exp_d = ed; v.exp_load = el; v.chk_load = cl;
    v.exp_wr = ew; v.exp_cyc = ec; v.exp_err = ee; v.exp_addr = ed ? da : ia;
    return v;
  endfunction

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
  endtask

  task automatic wait_pulse(input int budget, output int k, output bit got,
                            output int ren_n, output int wen_n, output logic [31:0] first_addr);
    k = 0; got = 0; ren_n = 0; wen_n = 0; first_addr = '0;
    while (!got && k < budget) begin
      @(negedge CLK);
      k++;
      if (k == 1) first_addr = ramaddr;
      if (ramREN) ren_n++;
      if (ramWEN) wen_n++;
      if (!iwait || !dwait) got = 1;
    end
    if (!got) sb_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int k, ren_n, wen_n;
    bit got, op_ok;
    logic [31:0] a0;
    @(posedge CLK); #1;
    ram_lat = v.lat; ram_stuck = v.stuck;
    iREN = v.iren; iaddr = v.iaddr; dREN = v.dren; dWEN = v.dwen; daddr = v.daddr; dstore = v.dstore;
    sb_push(v.exp_d, v.exp_load, v.chk_load);
    wait_pulse(40, k, got, ren_n, wen_n, a0);
    chk("latency", 32'(k), 32'(v.exp_cyc));
    chk("lookahead_addr", a0, v.exp_addr);
    op_ok = v.exp_wr ? (ren_n == 0 && wen_n > 0) : (wen_n == 0 && ren_n > 0);
    chk("ram_op", {31'b0, op_ok}, 32'h1);
    @(posedge CLK); #1;
    clear_inputs();
    ram_stuck = 0;
    @(negedge CLK);
    chk("err", {31'b0, err}, {31'b0, v.exp_err});
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1;
    @(negedge CLK);
    @(posedge CLK); #1;
    RST = 0;
  endtask

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ren_n, wen_n;
    bit got;
    logic [31:0] a0;

    vecs[0] = mk(0, 0, 1, 32'h40, 0, 0, 32'h0,  32'h0,        0, 32'h12345678, 1, 0, 2, 0);
    vecs[1] = mk(0, 0, 0, 32'h0,  0, 1, 32'h84, 32'hDEADBEEF, 1, 32'h0,        0, 1, 2, 0);
    vecs[2] = mk(0, 0, 0, 32'h0,  1, 0, 32'h84, 32'h0,        1, 32'hDEADBEEF, 1, 0, 2, 0);
    vecs[3] = mk(2, 0, 1, 32'h44, 0, 0, 32'h0,  32'h0,        0, 32'h10000044, 1, 0, 4, 0);
    vecs[4] = mk(3, 0, 0, 32'h0,  1, 1, 32'h90, 32'h11112222, 1, 32'h0,        0, 1, 5, 0);
    vecs[5] = mk(1, 0, 0, 32'h0,  1, 0, 32'h90, 32'h0,        1, 32'h11112222, 1, 0, 3, 0);
`ifdef MEM_ARB_RR_EN
    vecs[6] = mk(0, 0, 1, 32'h40, 1, 0, 32'h84, 32'h0,        0, 32'h12345678, 1, 0, 2, 0);
`else
    vecs[6] = mk(0, 0, 1, 32'h40, 1, 0, 32'h84, 32'h0,        1, 32'hDEADBEEF, 1, 0, 2, 0);
`endif
    vecs[7] = mk(0, 1, 0, 32'h0,  1, 0, 32'h88, 32'h0,        1, 32'hBAD1BAD1, 1, 0, 17, 1);
    vecs[8] = mk(1, 0, 1, 32'h48, 0, 0, 32'h0,  32'h0,        0, 32'h10000048, 1, 0, 3, 1);

    // Reset state
    RST = 1;
    clear_inputs();
    repeat (2) @(negedge CLK);
    chk("rst_iwait", {31'b0, iwait}, 32'h1);
    chk("rst_dwait", {31'b0, dwait}, 32'h1);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    chk("rst_ramREN", {31'b0, ramREN}, 32'h0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    @(posedge CLK); #1;
    RST = 0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Write then read at the same address, back to back, LAT=0
    @(posedge CLK); #1;
    ram_lat = 0;
    dWEN = 1; daddr = 32'h80; dstore = 32'hCAFEF00D;
    sb_push(1, 32'h0, 0);
    wait_pulse(10, k, got, ren_n, wen_n, a0);
    chk("wr_latency", 32'(k), 32'd2);
    @(posedge CLK); #1;
    dWEN = 0; dREN = 1;
    sb_push(1, 32'hCAFEF00D, 1);
    wait_pulse(10, k, got, ren_n, wen_n, a0);
    chk("rd_pulse_gap", 32'(k), 32'd2);
    @(posedge CLK); #1;
    clear_inputs();

    // Reset in grant cycle 1 of a LAT=3 write; request then re-issues
    @(posedge CLK); #1;
    ram_lat = 3;
    dWEN = 1; daddr = 32'hA0; dstore = 32'h5555AAAA;
    @(posedge CLK); #1;
    chk("pre_rst_ramWEN", {31'b0, ramWEN}, 32'h1);
    RST = 1;
    #1;
    chk("mid_rst_ramWEN", {31'b0, ramWEN}, 32'h0);
    chk("mid_rst_ramREN", {31'b0, ramREN}, 32'h0);
    chk("mid_rst_dwait", {31'b0, dwait}, 32'h1);
    chk("mid_rst_err", {31'b0, err}, 32'h0);
    @(posedge CLK); #1;
    RST = 0;
    sb_push(1, 32'h0, 0);
    wait_pulse(20, k, got, ren_n, wen_n, a0);
    chk("reissue_latency", 32'(k), 32'd5);
    @(posedge CLK); #1;
    clear_inputs();
    run_vec(mk(0, 0, 0, 32'h0, 1, 0, 32'hA0, 32'h0, 1, 32'h5555AAAA, 1, 0, 2, 0));

    // Continuous contention, LAT=2, from a fresh reset
    do_reset();
    ram_lat = 2;
`ifdef MEM_ARB_RR_EN
    sb_push(1, 32'hCAFEF00D, 1); sb_push(0, 32'h12345678, 1);
    sb_push(1, 32'hCAFEF00D, 1); sb_push(0, 32'h12345678, 1);
`else
    for (int p = 0; p < 4; p++) sb_push(1, 32'hCAFEF00D, 1);
`endif
    @(posedge CLK); #1;
    iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h80;
    for (int p = 0; p < 4; p++) begin
      wait_pulse(12, k, got, ren_n, wen_n, a0);
      chk("contention_gap", 32'(k), 32'd4);
    end
    @(posedge CLK); #1;
    clear_inputs();
    repeat (3) @(negedge CLK);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
